// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
// Request/response bundle for the multi-cycle adder/subtractor.
//   master : drives start, sub, cin, a, b; observes busy, done, sum, cout, ovf, zero
//   slave  : the arithmetic unit (mirror image of master)
interface serial_add_sub_if #(
  parameter int WIDTH = 8
) ();
  // request
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  // response / status
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Multi-cycle adder/subtractor. Each RUN cycle pushes BPC operand bits
// through a ripple of BPC full-adder cells, with the carry held in a
// register between cycles, so a WIDTH-bit operation takes WIDTH/BPC cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_add_sub_if.slave
//            start/sub/cin/a/b : request, sampled only when not busy
//            busy              : operation in progress
//            done              : one-cycle completion pulse
//            sum/cout/ovf/zero : result and flags, held until next completion

// One bit of the ripple chain.
module serial_add_sub_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_sub_if.slave    bus
);
  localparam int N  = (BPC > 0) ? (WIDTH / BPC) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be >= 2 and BPC must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b;       // operand shift registers, LSB chunk consumed first
  logic [WIDTH-1:0] r_res;          // result fills from the top, one chunk per cycle
  logic             r_carry;        // carry between chunks
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero;

  logic             w_accept, w_last;
  logic [BPC:0]     w_c;            // ripple carries through the current chunk
  logic [BPC-1:0]   w_s;
  logic [WIDTH-1:0] w_res_nxt;

  // ---------------------------------------------------------------- chunk adder
  assign w_c[0] = r_carry;

  for (genvar i = 0; i < BPC; i++) begin : g_lane
    serial_add_sub_fa u_fa (
      .i_a (r_a[i]),
      .i_b (r_b[i]),
      .i_c (w_c[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i+1])
    );
  end

  // After N shifts the first chunk has reached bit 0, so the word is in order.
  always_comb begin
    w_res_nxt                  = r_res >> BPC;
    w_res_nxt[WIDTH-1 -: BPC]  = w_s;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here
        if (r_cnt == CW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // back-to-back: a start on the done cycle launches the next op
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      // Subtract is a + ~b + ~borrow: invert b once at capture and seed the
      // carry with the inverted borrow, then the chain only ever adds.
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.cin ^ bus.sub;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> BPC;
      r_b     <= r_b >> BPC;
      r_res   <= w_res_nxt;
      r_carry <= w_c[BPC];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // Visible results change only here, all together.
        // In the last chunk, lane BPC-1 is bit WIDTH-1, so w_c[BPC-1]
        // is the carry into the MSB.
        r_sum  <= w_res_nxt;
        r_cout <= w_c[BPC];
        r_ovf  <= w_c[BPC] ^ w_c[BPC-1];
        r_zero <= ~|w_res_nxt;
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // shared stimulus for the four WIDTH=8 instances (BPC = 1,2,4,8)
  logic       t_start = 1'b0, t_sub = 1'b0, t_cin = 1'b0;
  logic [7:0] t_a = '0, t_b = '0;

  wire [3:0]      busy_v, done_v, cout_v, ovf_v, zero_v;
  wire [3:0][7:0] sum_v;

  for (genvar g = 0; g < 4; g++) begin : g8
    serial_add_sub_if #(.WIDTH(8)) bus ();
    assign bus.start = t_start;
    assign bus.sub   = t_sub;
    assign bus.cin   = t_cin;
    assign bus.a     = t_a;
    assign bus.b     = t_b;
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign zero_v[g] = bus.zero;
    assign sum_v[g]  = bus.sum;
    serial_add_sub #(.WIDTH(8), .BPC(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  serial_add_sub_if #(.WIDTH(4)) w4 ();
  serial_add_sub #(.WIDTH(4), .BPC(2)) dut_w4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w4)
  );

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum;
    logic       cout, ovf, zero;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {sum[7:0], cout, ovf, zero}.
  function automatic logic [10:0] model(input int w, input int a, input int b,
                                        input int ci, input int s);
    int full, mask, half, sa, sb, sr, sm;
    logic co, ov;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    full = s ? (a - b - ci) : (a + b + ci);
    sm   = full & mask;
    co   = s ? (full >= 0) : (full > mask);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    sr   = s ? (sa - sb - ci) : (sa + sb + ci);
    ov   = (sr < -half) || (sr >= half);
    return {sm[7:0], co, ov, (sm == 0)};
  endfunction

  // One op on all four 8-bit instances; checks results, latency, busy length.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic s, input logic [10:0] exp, input string nm);
    int lat[4];
    int bcnt;
    @(negedge clk);
    t_a = a; t_b = b; t_cin = ci; t_sub = s; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    bcnt = busy_v[0] ? 1 : 0;
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int c = 1; c <= 20 && lat[0] == 0; c++) begin
      @(posedge clk); #1;
      if (busy_v[0]) bcnt++;
      chk($sformatf("%s busy&done", nm), {28'd0, busy_v & done_v}, 32'd0);
      for (int g = 0; g < 4; g++)
        if (lat[g] == 0 && done_v[g]) lat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s bpc%0d result", nm, 1 << g),
          {21'd0, sum_v[g], cout_v[g], ovf_v[g], zero_v[g]}, {21'd0, exp});
      chk($sformatf("%s bpc%0d latency", nm, 1 << g), lat[g], 8 >> g);
    end
    chk($sformatf("%s busy cycles", nm), bcnt, 8);
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s);
    @(negedge clk);
    t_a = a; t_b = b; t_cin = ci; t_sub = s; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
  endtask

  task automatic wait_main(input int maxc, output int lat);
    lat = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic logic [31:0] main_res();
    return {21'd0, sum_v[0], cout_v[0], ovf_v[0], zero_v[0]};
  endfunction

  vec_t tbl[8];

  initial begin
    int lat;
    int seen;
    logic [7:0] ra, rb;
    logic rc, rs;

    tbl[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0};

    w4.start = 1'b0; w4.sub = 1'b0; w4.cin = 1'b0; w4.a = '0; w4.b = '0;

    // power-on reset, asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("reset outputs", {busy_v[0], done_v[0], main_res()}, 32'd0);
    chk("reset w4 outputs", {w4.busy, w4.done, w4.sum, w4.cout, w4.ovf, w4.zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 8; i++)
      do_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero}, $sformatf("tbl%0d", i));

    // asynchronous reset mid-cycle with non-zero held results
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async reset clears", {busy_v[0], done_v[0], main_res()}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      do_op8(ra, rb, rc, rs, model(8, ra, rb, rc, rs), $sformatf("rnd%0d", i));
    end

    // start during RUN is ignored
    launch8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    t_a = 8'hFF; t_b = 8'hFF; t_sub = 1'b1; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    wait_main(20, lat);
    chk("ignored start latency", lat, 5);
    chk("ignored start result", main_res(), {21'd0, 8'h46, 3'b000});

    // start on the done cycle is accepted back-to-back
    launch8(8'h20, 8'h22, 1'b0, 1'b0);
    wait_main(20, lat);
    chk("b2b first latency", lat, 8);
    t_a = 8'h01; t_b = 8'h02; t_cin = 1'b0; t_sub = 1'b1; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    chk("b2b done/busy after accept", {30'd0, done_v[0], busy_v[0]}, 32'd1);
    chk("b2b held result", main_res(), {21'd0, 8'h42, 3'b000});
    wait_main(20, lat);
    chk("b2b second latency", lat, 8);
    chk("b2b second result", main_res(), {21'd0, 8'hFF, 3'b000});

    // reset during RUN cycle 4: abort, no done
    launch8(8'h55, 8'h0A, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("reset mid-run outputs", {busy_v[0], done_v[0], main_res()}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    chk("no activity after abort", seen, 0);

    // WIDTH=4, BPC=2: exhaustive
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            w4.a = 4'(a); w4.b = 4'(b); w4.cin = 1'(ci); w4.sub = 1'(s); w4.start = 1'b1;
            @(posedge clk); #1;
            w4.start = 1'b0;
            lat = 0;
            for (int c = 1; c <= 6 && lat == 0; c++) begin
              @(posedge clk); #1;
              if (w4.done) lat = c;
            end
            chk($sformatf("w4 %0d %0d %0d %0d latency", a, b, ci, s), lat, 2);
            chk($sformatf("w4 %0d %0d %0d %0d result", a, b, ci, s),
                {25'd0, w4.sum, w4.cout, w4.ovf, w4.zero}, {21'd0, model(4, a, b, ci, s)});
          end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
